ram_port_arbiter: RTL and testbench

- Sequential round-robin arbiter that shares the single RAM port among NREQ cache-side requesters: icache0=0, dcache0=1, icache1=2, dcache1=3.
- Sits between the cache/coherence control and the RAM model. It registers one owner per transaction and drives ramaddr/ramstore/ramREN/ramWEN from that owner.
- Returns ramload and a per-requester wait.
- Adds data-over-instruction priority and starvation promotion so no core is locked out under contention.

---
 rtl/arb_pkg.sv | 6 +
 rtl/cpu_types_pkg.sv | 5 +
 rtl/rr_pick.sv | 21 ++
 rtl/ram_port_arbiter.sv | 90 +++++++++
 tb/tb_ram_port_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: arbiter state type and default sizing
package arb_pkg;
  typedef enum logic {IDLE, OWN} arb_state_t;
  localparam int NREQ_DEFAULT = 4;
  localparam int STARVE_LIMIT_DEFAULT = 8;
endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU-wide word and RAM status types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first pending index after last_i, wrapping modulo N
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  int j;
  always_comb begin
    idx_o = '0;
    j = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if (pending_i[j[IW-1:0]]) idx_o = j[IW-1:0];
    end
  end
  assign valid_o = |pending_i;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin owner of the single RAM port with
// dcache priority and starvation promotion
module ram_port_arbiter
  import cpu_types_pkg::*, arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter bit DATA_PRIO = 1'b1,
  localparam int IW = $clog2(NREQ),
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NREQ-1:0] req_ren,
  input  logic [NREQ-1:0] req_wen,
  input  word_t           req_addr [NREQ],
  input  word_t           req_store [NREQ],
  output logic [NREQ-1:0] req_wait,
  output word_t           req_load,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  ramstate_t       ramstate,
  input  word_t           ramload,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);
  arb_state_t    state_q;
  logic [IW-1:0] owner_q, last_q, pick, rr_d_idx, rr_a_idx, starved_idx;
  logic          rr_d_vld, rr_a_vld, starved_vld, own_pend, own_on, ack;
  logic [NREQ-1:0] pending, dmask;
  logic [SW-1:0] starve_q [NREQ];

  assign pending = req_ren | req_wen;

  // descending scan leaves the lowest starved index as the winner
  always_comb begin
    dmask = '0;
    starved_vld = 1'b0;
    starved_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      dmask[i] = pending[i] & i[0];
      if (pending[i] && starve_q[i] >= SW'(STARVE_LIMIT)) begin
        starved_vld = 1'b1;
        starved_idx = IW'(i);
      end
    end
  end

  rr_pick #(.N(NREQ)) u_rr_data (.pending_i(dmask), .last_i(last_q), .idx_o(rr_d_idx), .valid_o(rr_d_vld));
  rr_pick #(.N(NREQ)) u_rr_all (.pending_i(pending), .last_i(last_q), .idx_o(rr_a_idx), .valid_o(rr_a_vld));

  assign pick = starved_vld ? starved_idx : (DATA_PRIO && rr_d_vld) ? rr_d_idx : rr_a_idx;

  assign own_pend = state_q == OWN && pending[owner_q];
  assign own_on   = own_pend && ramstate != ERROR;
  assign ack      = own_pend && ramstate == ACCESS;
  assign ramWEN   = own_on & req_wen[owner_q];
  assign ramREN   = own_on & req_ren[owner_q] & ~req_wen[owner_q];
  assign ramaddr  = state_q == OWN ? req_addr[owner_q] : '0;
  assign ramstore = state_q == OWN ? req_store[owner_q] : '0;
  assign req_wait = ~(NREQ'(ack) << owner_q);
  assign req_load = ramload;
  assign grant_id = owner_q;
  assign busy     = state_q == OWN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      for (int i = 0; i < NREQ; i++) starve_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (!pending[i]) starve_q[i] <= '0;
        else if (state_q == OWN && owner_q == IW'(i)) starve_q[i] <= ack ? '0 : starve_q[i];
        else if (starve_q[i] < SW'(STARVE_LIMIT)) starve_q[i] <= starve_q[i] + 1'b1;
      if (state_q == IDLE) begin
        if (rr_a_vld) begin
          owner_q <= pick;
          state_q <= OWN;
        end
      end else if (!own_pend || ack) begin
        state_q <= IDLE;
        last_q  <= owner_q;
      end else if (ramstate == ERROR) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of ram_port_arbiter, one instance per
// DATA_PRIO setting driven by the same stimulus
module tb_ram_port_arbiter;
  import cpu_types_pkg::*;
  logic CLK = 1'b0, nRST;
  logic [3:0] req_ren, req_wen;
  word_t req_addr [4], req_store [4];
  ramstate_t ramstate;
  word_t ramload;
  logic [3:0] wait_a, wait_b;
  word_t load_a, load_b, addr_a, addr_b, store_a, store_b;
  logic ren_a, ren_b, wen_a, wen_b, busy_a, busy_b;
  logic [1:0] gid_a, gid_b;
  int n_tests = 0, n_fail = 0;
  logic [1:0] exp_s [6] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd1};
  logic [3:0] ew;

  always #5 CLK = ~CLK;

  ram_port_arbiter #(.DATA_PRIO(1'b1)) u_dut (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store), .req_wait(wait_a), .req_load(load_a),
    .ramREN(ren_a), .ramWEN(wen_a), .ramaddr(addr_a), .ramstore(store_a),
    .ramstate(ramstate), .ramload(ramload), .grant_id(gid_a), .busy(busy_a));

  ram_port_arbiter #(.DATA_PRIO(1'b0)) u_rr (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store), .req_wait(wait_b), .req_load(load_b),
    .ramREN(ren_b), .ramWEN(wen_b), .ramaddr(addr_b), .ramstore(store_b),
    .ramstate(ramstate), .ramload(ramload), .grant_id(gid_b), .busy(busy_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; req_ren = '0; req_wen = '0; ramstate = FREE; ramload = '0;
    for (int i = 0; i < 4; i++) begin req_addr[i] = '0; req_store[i] = '0; end
    tick();
    chk("rst_wait", wait_a, 4'hF);
    chk("rst_ren", ren_a, 0);
    chk("rst_wen", wen_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_store", store_a, 0);
    chk("rst_gid", gid_a, 0);
    chk("rst_busy", busy_a, 0);
    nRST = 1'b1;
    // single read, RAM answers on its second cycle
    tick();
    req_ren = 4'b0010; req_addr[1] = 32'h40; ramstate = BUSY; #1;
    chk("rd_idle_ren", ren_a, 0);
    chk("rd_idle_wait", wait_a, 4'hF);
    tick();
    chk("rd_ren", ren_a, 1);
    chk("rd_addr", addr_a, 32'h40);
    chk("rd_gid", gid_a, 1);
    chk("rd_busy", busy_a, 1);
    chk("rd_wait_busy", wait_a, 4'hF);
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("rd_ack", wait_a, 4'b1101);
    chk("rd_load", load_a, 32'hDEADBEEF);
    tick();
    req_ren = '0; ramstate = FREE; #1;
    chk("rd_done_busy", busy_a, 0);
    chk("rd_done_wait", wait_a, 4'hF);
    chk("rd_done_gid", gid_a, 1);
    // round robin without data priority
    do_reset();
    req_ren = 4'hF; ramstate = ACCESS; #1;
    chk("rr_idle", busy_b, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      ew = ~(4'b0001 << (k % 4));
      chk("rr_gid", gid_b, k % 4);
      chk("rr_wait", wait_b, ew);
      tick();
      chk("rr_gap", busy_b, 0);
      chk("rr_gap_wait", wait_b, 4'hF);
    end
    req_ren = '0; ramstate = FREE;
    // data priority, write beats read on the same requester
    do_reset();
    req_ren = 4'b1001; req_wen = 4'b1000; req_addr[3] = 32'h80; req_store[3] = 32'h12345678; #1;
    tick();
    chk("dp_gid", gid_a, 3);
    chk("dp_wen", wen_a, 1);
    chk("dp_ren", ren_a, 0);
    chk("dp_addr", addr_a, 32'h80);
    chk("dp_store", store_a, 32'h12345678);
    ramstate = ACCESS; #1;
    chk("dp_ack3", wait_a, 4'b0111);
    tick();
    req_ren = 4'b0001; req_wen = '0; ramstate = FREE; #1;
    chk("dp_gap", busy_a, 0);
    tick();
    chk("dp_gid0", gid_a, 0);
    chk("dp_ren0", ren_a, 1);
    chk("dp_wen0", wen_a, 0);
    ramstate = ACCESS; #1;
    chk("dp_ack0", wait_a, 4'b1110);
    tick();
    req_ren = '0; ramstate = FREE;
    // starvation promotion of icache 0 against two dcaches
    do_reset();
    req_ren = 4'b1011; ramstate = ACCESS; #1;
    for (int k = 0; k < 6; k++) begin
      tick();
      ew = ~(4'b0001 << exp_s[k]);
      chk("st_gid", gid_a, exp_s[k]);
      chk("st_wait", wait_a, ew);
      tick();
      chk("st_gap", busy_a, 0);
    end
    req_ren = '0; ramstate = FREE;
    // ERROR drops enables and retries without ack
    do_reset();
    req_ren = 4'b0100; req_addr[2] = 32'h100; ramstate = BUSY; #1;
    tick();
    chk("er_ren", ren_a, 1);
    chk("er_gid", gid_a, 2);
    ramstate = ERROR; #1;
    chk("er_ren_drop", ren_a, 0);
    chk("er_wait", wait_a, 4'hF);
    tick();
    ramstate = BUSY; #1;
    chk("er_idle", busy_a, 0);
    chk("er_idle_wait", wait_a, 4'hF);
    tick();
    chk("er_regrant", gid_a, 2);
    chk("er_reren", ren_a, 1);
    chk("er_addr", addr_a, 32'h100);
    ramstate = ACCESS; #1;
    chk("er_ack", wait_a, 4'b1011);
    // owner abort gives no ack
    tick();
    req_ren = 4'b0010; ramstate = BUSY; #1;
    tick();
    chk("ab_gid", gid_a, 1);
    chk("ab_busy", busy_a, 1);
    req_ren = '0; ramstate = ACCESS; #1;
    chk("ab_ren", ren_a, 0);
    chk("ab_wait", wait_a, 4'hF);
    tick();
    chk("ab_idle", busy_a, 0);
    chk("ab_idle_wait", wait_a, 4'hF);
    // reset asserted while owner writes
    req_wen = 4'b0100; req_ren = 4'b0001; ramstate = BUSY; #1;
    tick();
    chk("rm_gid", gid_a, 2);
    chk("rm_wen", wen_a, 1);
    nRST = 1'b0; #1;
    chk("rm_wen_drop", wen_a, 0);
    chk("rm_wait", wait_a, 4'hF);
    chk("rm_busy", busy_a, 0);
    chk("rm_gid_rst", gid_a, 0);
    tick();
    nRST = 1'b1;
    tick();
    chk("rm_first_gid", gid_a, 0);
    chk("rm_first_ren", ren_a, 1);
    chk("rm_first_wen", wen_a, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
